// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// alu_exec_unit : RV32I ALU/branch execution stage, one op per cycle, 1-cycle CDB latency
// Revision: 1.0
// ============================================================================
module alu_exec_unit #(
   parameter int DATA_W = 32,
   parameter int ROB_W  = 5,
   parameter int OP_W   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback_signal,
   input  logic [OP_W-1:0]   optype_in,
   input  logic [ROB_W-1:0]  rd_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] Vi_in,
   input  logic [DATA_W-1:0] Vj_in,
   input  logic [DATA_W-1:0] imm_in,
   output logic              alu_has_result,
   output logic [ROB_W-1:0]  alias_from_alu,
   output logic [DATA_W-1:0] result_from_alu,
   output logic              is_branch,
   output logic              branch_taken,
   output logic [DATA_W-1:0] target_pc
);

   // Opcode-type encodings shared with the reservation station
   localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
   localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
   localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
   localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
   localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
   localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
   localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
   localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
   localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
   localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
   localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
   localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
   localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
   localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
   localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
   localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
   localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
   localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
   localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
   localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

   logic              w_use_imm;
   logic [DATA_W-1:0] w_op2;
   logic [4:0]        w_shamt;
   logic [DATA_W-1:0] w_pc4;
   logic [DATA_W-1:0] w_pc_imm;
   logic              w_lt;
   logic              w_ltu;

   logic              valid_d;
   logic [DATA_W-1:0] result_d;
   logic              is_branch_d;
   logic              taken_d;
   logic [DATA_W-1:0] target_d;

   logic              valid_q;
   logic [ROB_W-1:0]  alias_q;
   logic [DATA_W-1:0] result_q;
   logic              is_branch_q;
   logic              taken_q;
   logic [DATA_W-1:0] target_q;

   // I-type ALU ops occupy a contiguous encoding range
   assign w_use_imm = (optype_in >= OP_ADDI) && (optype_in <= OP_SRAI);
   assign w_op2     = w_use_imm ? imm_in : Vj_in;
   assign w_shamt   = w_op2[4:0];
   assign w_pc4     = pc_in + DATA_W'(4);
   assign w_pc_imm  = pc_in + imm_in;
   assign w_lt      = $signed(Vi_in) < $signed(w_op2);
   assign w_ltu     = Vi_in < w_op2;

   always_comb begin
      valid_d     = 1'b1;
      result_d    = '0;
      is_branch_d = 1'b0;
      taken_d     = 1'b0;
      target_d    = w_pc4;
      case (optype_in)
         OP_NOP:               valid_d = 1'b0;
         OP_LUI:               result_d = imm_in;
         OP_AUIPC:             result_d = w_pc_imm;
         OP_JAL: begin
            result_d    = w_pc4;
            target_d    = w_pc_imm;
            is_branch_d = 1'b1;
            taken_d     = 1'b1;
         end
         OP_JALR: begin
            result_d    = w_pc4;
            target_d    = (Vi_in + imm_in) & ~DATA_W'(1);
            is_branch_d = 1'b1;
            taken_d     = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            is_branch_d = 1'b1;
            case (optype_in)
               OP_BEQ:  taken_d = (Vi_in == Vj_in);
               OP_BNE:  taken_d = (Vi_in != Vj_in);
               OP_BLT:  taken_d = w_lt;
               OP_BGE:  taken_d = !w_lt;
               OP_BLTU: taken_d = w_ltu;
               default: taken_d = !w_ltu;
            endcase
            target_d = taken_d ? w_pc_imm : w_pc4;
         end
         OP_ADDI, OP_ADD:      result_d = Vi_in + w_op2;
         OP_SUB:               result_d = Vi_in - w_op2;
         OP_SLTI, OP_SLT:      result_d = DATA_W'(w_lt);
         OP_SLTIU, OP_SLTU:    result_d = DATA_W'(w_ltu);
         OP_XORI, OP_XOR:      result_d = Vi_in ^ w_op2;
         OP_ORI, OP_OR:        result_d = Vi_in | w_op2;
         OP_ANDI, OP_AND:      result_d = Vi_in & w_op2;
         OP_SLLI, OP_SLL:      result_d = Vi_in << w_shamt;
         OP_SRLI, OP_SRL:      result_d = Vi_in >> w_shamt;
         OP_SRAI, OP_SRA:      result_d = $signed(Vi_in) >>> w_shamt;
         default:              valid_d = 1'b0;
      endcase
   end

   // Rollback outranks rdy; NOP and rollback leave the data fields untouched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= 1'b0;
         alias_q     <= '0;
         result_q    <= '0;
         is_branch_q <= 1'b0;
         taken_q     <= 1'b0;
         target_q    <= '0;
      end else if (rollback_signal) begin
         valid_q     <= 1'b0;
         is_branch_q <= 1'b0;
         taken_q     <= 1'b0;
      end else if (rdy) begin
         if (valid_d) begin
            valid_q     <= 1'b1;
            alias_q     <= rd_in;
            result_q    <= result_d;
            is_branch_q <= is_branch_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
         end else begin
            valid_q     <= 1'b0;
            is_branch_q <= 1'b0;
            taken_q     <= 1'b0;
         end
      end
   end

   assign alu_has_result  = valid_q;
   assign alias_from_alu  = alias_q;
   assign result_from_alu = result_q;
   assign is_branch       = is_branch_q;
   assign branch_taken    = taken_q;
   assign target_pc       = target_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_unit : self-checking bench for alu_exec_unit against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_alu_exec_unit;

   localparam int NOP = 0, LUI = 1, AUIPC = 2, JAL = 3, JALR = 4;
   localparam int BEQ = 5, BNE = 6, BLT = 7, BGE = 8, BLTU = 9, BGEU = 10;
   localparam int ADDI = 11, SLTI = 12, SLTIU = 13, XORI = 14, ORI = 15, ANDI = 16;
   localparam int SLLI = 17, SRLI = 18, SRAI = 19;
   localparam int ADD = 20, SUB = 21, SLL = 22, SLT = 23, SLTU = 24, XOR = 25;
   localparam int SRL = 26, SRA = 27, OR = 28, AND = 29;

   typedef struct packed {
      logic        v;
      logic [4:0]  al;
      logic [31:0] res;
      logic        b;
      logic        t;
      logic [31:0] tgt;
   } out_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        rollback_signal;
   logic [5:0]  optype_in;
   logic [4:0]  rd_in;
   logic [31:0] pc_in, Vi_in, Vj_in, imm_in;
   logic        alu_has_result;
   logic [4:0]  alias_from_alu;
   logic [31:0] result_from_alu;
   logic        is_branch;
   logic        branch_taken;
   logic [31:0] target_pc;

   out_t got;
   out_t exp_s;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.DATA_W(32), .ROB_W(5), .OP_W(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
      .optype_in(optype_in), .rd_in(rd_in), .pc_in(pc_in), .Vi_in(Vi_in),
      .Vj_in(Vj_in), .imm_in(imm_in),
      .alu_has_result(alu_has_result), .alias_from_alu(alias_from_alu),
      .result_from_alu(result_from_alu), .is_branch(is_branch),
      .branch_taken(branch_taken), .target_pc(target_pc)
   );

   assign got = {alu_has_result, alias_from_alu, result_from_alu, is_branch, branch_taken, target_pc};

   function automatic out_t compute(out_t cur, int op, logic [4:0] rd, logic [31:0] pc,
                                    logic [31:0] vi, logic [31:0] vj, logic [31:0] imm);
      out_t n;
      logic [31:0] bv;
      longint unsigned a, b, p, i;
      int sh;
      bit tk;
      bit is_imm;
      is_imm = (op == ADDI || op == SLTI || op == SLTIU || op == XORI || op == ORI ||
                op == ANDI || op == SLLI || op == SRLI || op == SRAI);
      bv = is_imm ? imm : vj;
      a = vi; b = bv; p = pc; i = imm;
      sh = int'(bv % 32);
      n = cur;
      n.v = 1'b1; n.al = rd; n.b = 1'b0; n.t = 1'b0; n.tgt = 32'(p + 4);
      tk = 1'b0;
      case (op)
         LUI:        n.res = imm;
         AUIPC:      n.res = 32'(p + i);
         JAL:        begin n.res = 32'(p + 4); n.tgt = 32'(p + i); n.b = 1; n.t = 1; end
         JALR:       begin n.res = 32'(p + 4); n.tgt = 32'(a + i) & 32'hFFFF_FFFE; n.b = 1; n.t = 1; end
         BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
            case (op)
               BEQ:     tk = (vi == vj);
               BNE:     tk = (vi != vj);
               BLT:     tk = (int'(vi) < int'(vj));
               BGE:     tk = (int'(vi) >= int'(vj));
               BLTU:    tk = (a < longint'(vj));
               default: tk = (a >= longint'(vj));
            endcase
            n.res = 32'd0; n.b = 1'b1; n.t = tk;
            n.tgt = tk ? 32'(p + i) : 32'(p + 4);
         end
         ADD, ADDI:  n.res = 32'(a + b);
         SUB:        n.res = 32'(a + 64'h1_0000_0000 - b);
         SLT, SLTI:  n.res = (int'(vi) < int'(bv)) ? 32'd1 : 32'd0;
         SLTU, SLTIU: n.res = (a < b) ? 32'd1 : 32'd0;
         XOR, XORI:  n.res = vi ^ bv;
         OR, ORI:    n.res = vi | bv;
         AND, ANDI:  n.res = vi & bv;
         SLL, SLLI:  n.res = 32'(a << sh);
         SRL, SRLI:  n.res = 32'(a >> sh);
         SRA, SRAI:  n.res = vi[31] ? ~((~vi) >> sh) : (vi >> sh);
         default:    begin n = cur; n.v = 1'b0; n.b = 1'b0; n.t = 1'b0; end
      endcase
      return n;
   endfunction

   task automatic drive(int op, logic [4:0] rd, logic [31:0] pc, logic [31:0] vi,
                        logic [31:0] vj, logic [31:0] imm);
      optype_in = 6'(op); rd_in = rd; pc_in = pc; Vi_in = vi; Vj_in = vj; imm_in = imm;
   endtask

   // Advance one clock edge, updating the expected stage from the inputs seen at that edge
   task automatic tick();
      if (!rst) exp_s = '0;
      else if (rollback_signal) begin exp_s.v = 0; exp_s.b = 0; exp_s.t = 0; end
      else if (rdy) exp_s = compute(exp_s, int'(optype_in), rd_in, pc_in, Vi_in, Vj_in, imm_in);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; rdy = 1'b1; rollback_signal = 1'b0; exp_s = '0;
      drive(ADD, 5'd1, 32'h0, 32'h1, 32'h2, 32'h0);
      #1;
      checks++;
      if (got !== 32'd0) begin failures++; $display("FAIL reset_init actual=%h expected=%h", got, 72'h0); end
      #1 rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(ADD, 5'(k + 2), 32'h0, 32'(k * 11), 32'h5, 32'h0);
         tick();
      end
      checks++;
      if (got !== exp_s || !alu_has_result) begin
         failures++; $display("FAIL reset_prestream actual=%h expected=%h", got, exp_s);
      end
      #2 rst = 1'b0;
      #1;
      exp_s = '0;
      checks++;
      if (got !== 72'h0) begin failures++; $display("FAIL reset_async actual=%h expected=0", got); end
      tick();
      #2 rst = 1'b1;
      drive(ADD, 5'd7, 32'h0, 32'd3, 32'd4, 32'h0);
      tick();
      checks++;
      if (got !== exp_s || alu_has_result !== 1'b1 || alias_from_alu !== 5'd7 || result_from_alu !== 32'd7) begin
         failures++; $display("FAIL reset_first_op actual=%h expected=%h", got, exp_s);
      end
      drive(NOP, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
      checks++;
      if (got !== exp_s || alu_has_result !== 1'b0 || result_from_alu !== 32'd7) begin
         failures++; $display("FAIL reset_nop actual=%h expected=%h", got, exp_s);
      end
   endtask

   task automatic test_signed_shift();
      drive(SLT, 5'd1, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0); tick();
      checks++;
      if (got !== exp_s || result_from_alu !== 32'd1) begin failures++; $display("FAIL slt actual=%h expected=%h", got, exp_s); end
      drive(SLTU, 5'd2, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0); tick();
      checks++;
      if (got !== exp_s || result_from_alu !== 32'd0) begin failures++; $display("FAIL sltu actual=%h expected=%h", got, exp_s); end
      drive(SRAI, 5'd3, 32'h0, 32'h8000_0000, 32'h0, 32'h401); tick();
      checks++;
      if (got !== exp_s || result_from_alu !== 32'hC000_0000) begin failures++; $display("FAIL srai actual=%h expected=%h", got, exp_s); end
      drive(SUB, 5'd4, 32'h0, 32'd0, 32'd1, 32'h0); tick();
      checks++;
      if (got !== exp_s || result_from_alu !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sub actual=%h expected=%h", got, exp_s); end
   endtask

   task automatic test_control();
      drive(BNE, 5'd5, 32'h100, 32'd1, 32'd2, 32'hFFFF_FFF8); tick();
      checks++;
      if (got !== exp_s || is_branch !== 1'b1 || branch_taken !== 1'b1 || target_pc !== 32'hF8 || result_from_alu !== 32'd0) begin
         failures++; $display("FAIL bne actual=%h expected=%h", got, exp_s);
      end
      drive(BEQ, 5'd6, 32'h100, 32'd1, 32'd2, 32'hFFFF_FFF8); tick();
      checks++;
      if (got !== exp_s || is_branch !== 1'b1 || branch_taken !== 1'b0 || target_pc !== 32'h104) begin
         failures++; $display("FAIL beq actual=%h expected=%h", got, exp_s);
      end
      drive(JALR, 5'd7, 32'h20, 32'h1003, 32'h0, 32'd4); tick();
      checks++;
      if (got !== exp_s || target_pc !== 32'h1006 || result_from_alu !== 32'h24 || branch_taken !== 1'b1) begin
         failures++; $display("FAIL jalr actual=%h expected=%h", got, exp_s);
      end
   endtask

   task automatic test_pause();
      drive(ADD, 5'd3, 32'h0, 32'd10, 32'd20, 32'h0); tick();
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(int'($urandom_range(1, 29)), 5'($urandom), $urandom, $urandom, $urandom, $urandom);
         tick();
         checks++;
         if (got !== exp_s || alu_has_result !== 1'b1 || result_from_alu !== 32'd30 || alias_from_alu !== 5'd3) begin
            failures++; $display("FAIL pause_hold%0d actual=%h expected=%h", k, got, exp_s);
         end
      end
      rdy = 1'b1;
      drive(ADD, 5'd4, 32'h0, 32'd1, 32'd1, 32'h0); tick();
      checks++;
      if (got !== exp_s || result_from_alu !== 32'd2 || alias_from_alu !== 5'd4) begin
         failures++; $display("FAIL pause_resume actual=%h expected=%h", got, exp_s);
      end
   endtask

   task automatic test_rollback();
      drive(ADD, 5'd9, 32'h0, 32'd5, 32'd6, 32'h0); tick();
      drive(ORI, 5'd10, 32'h0, 32'hF0, 32'h0, 32'h0F);
      rollback_signal = 1'b1; tick();
      checks++;
      if (got !== exp_s || alu_has_result !== 1'b0) begin failures++; $display("FAIL rollback_clear actual=%h expected=%h", got, exp_s); end
      rollback_signal = 1'b0;
      drive(NOP, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0); tick();
      checks++;
      if (got !== exp_s || alu_has_result !== 1'b0 || result_from_alu === 32'hFF) begin
         failures++; $display("FAIL rollback_discard actual=%h expected=%h", got, exp_s);
      end
      drive(JAL, 5'd11, 32'h40, 32'h0, 32'h0, 32'h10); tick();
      rdy = 1'b0; rollback_signal = 1'b1; tick();
      checks++;
      if (got !== exp_s || alu_has_result !== 1'b0 || is_branch !== 1'b0 || branch_taken !== 1'b0) begin
         failures++; $display("FAIL rollback_paused actual=%h expected=%h", got, exp_s);
      end
      rdy = 1'b1; rollback_signal = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 16; k++) begin
         drive(ADDI, 5'(k), 32'h0, 32'(k * 100), 32'h0, 32'(k)); tick();
         checks++;
         if (got !== exp_s || alu_has_result !== 1'b1 || alias_from_alu !== 5'(k) || result_from_alu !== 32'(k * 101)) begin
            failures++; $display("FAIL throughput%0d actual=%h expected=%h", k, got, exp_s);
         end
      end
      drive(NOP, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0); tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         drive(int'($urandom_range(0, 63)), 5'($urandom), $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? Vi_in : $urandom, $urandom);
         rdy = ($urandom_range(0, 7) != 0);
         rollback_signal = ($urandom_range(0, 15) == 0);
         tick();
         checks++;
         if (got !== exp_s) begin failures++; $display("FAIL random%0d actual=%h expected=%h", k, got, exp_s); end
      end
      rdy = 1'b1; rollback_signal = 1'b0;
   endtask

   initial begin
      test_reset();
      test_signed_shift();
      test_control();
      test_pause();
      test_rollback();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
